imem_loader: RTL and testbench
==============================

# imem_loader

Hardware program loader for the single-cycle MIPS core: the writing side of the instruction memory, where the bench is the reading side that observes PC, instruction and register state. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit words and drives the instruction-memory write port. While loading, it holds the core in reset; it then reports done or error.

## Interface
- `ADDR_WIDTH`, default 8: instruction-memory word-address width. Depth = 2**ADDR_WIDTH words.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. Name kept from the codebase; polarity and asynchronicity are fixed.
- `start` in 1: one-cycle pulse that begins a load. Ignored unless in IDLE, DONE or ERR.
- `in_valid` in 1: byte-stream valid.
- `in_data` in 8: byte-stream data.
- `in_ready` out 1: loader can accept a byte.
- `imem_we` out 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` out ADDR_WIDTH: word address. The byte address is `imem_addr<<2`.
- `imem_data` out 32: word to write.
- `cpu_hold` out 1: forces the core's reset while loading.
- `done` out 1: load completed with a good checksum.
- `error` out 1: length overflow or checksum mismatch.
- `words_loaded` out ADDR_WIDTH+1: count of words written in the current or last load.

## Operation
- Frame format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N×4 data bytes, each word MSB first.
  - CSUM: XOR of all data bytes. Length bytes are excluded.
- Acceptance: a byte is accepted on a rising edge with `in_valid && in_ready`.
- States:
  - IDLE: reset state.
  - LEN_HI
  - LEN_LO
  - DATA
  - CSUM
  - DONE
  - ERR
- Transitions:
  - IDLE/DONE/ERR + `start` → LEN_HI. Clears `done`, `error`, `words_loaded`, the byte counter, the address (to 0) and the checksum accumulator.
  - LEN_HI, accepted byte → LEN_LO.
  - LEN_LO, accepted byte:
    - N > 2**ADDR_WIDTH → ERR.
    - N == 0 → CSUM.
    - Otherwise → DATA.
  - DATA: each byte is shifted into the assembler and XORed into the accumulator. On the 4th byte of a word, the word is registered for writing. After the Nth word → CSUM.
  - CSUM, accepted byte: equal to the accumulator → DONE, otherwise → ERR.
- `in_ready`:
  - 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise.
  - Never depends on `in_valid` in the same cycle.
- `cpu_hold`:
  - 1 in LEN_HI through CSUM, and in ERR.
  - 0 in IDLE and DONE.
- Words already written before an ERR stay in memory. No rollback.
- Address arithmetic: `imem_addr` increments after each write. With N == 2**ADDR_WIDTH, the final write is at address 2**ADDR_WIDTH−1. The address wrap after it is not observable.

## Timing
- Reset values:
  - `in_ready`, `imem_we`, `cpu_hold`, `done`, `error`: 0.
  - `imem_addr`, `imem_data`: 0.
  - `words_loaded`: 0.
  - State: IDLE.
- `start` sampled at edge t: the state is LEN_HI and `cpu_hold`=`in_ready`=1 from t+ onwards.
- Write latency: the 4th byte of a word is accepted at edge t. `imem_we`=1 with the valid addr/data for exactly the cycle after t. `words_loaded` increments at edge t+1.
- Full rate: back-to-back bytes every cycle are sustained. Maximum throughput is one word per 4 cycles.
- Stalls: `in_valid` low between bytes stalls with no state change.
- Completion: the CSUM byte is accepted at edge t. `done` or `error` is 1 from t+; `cpu_hold` drops from t+ on success. The final word's `imem_we` and the CSUM acceptance may fall in consecutive cycles.
- Reset mid-load: all outputs return to their reset values immediately. The partial word is discarded.
- `start` coinciding with an accepted byte in DATA: `start` is ignored and the byte is processed normally.

## Structure
- Shared header `mips_defs.vh` holds:
  - the state encodings (3-bit localparams);
  - the frame-field constants (LEN_BYTES=2, WORD_BYTES=4).
- Sub-module `word_assembler`:
  - 8-to-32 shift register with a 2-bit byte counter.
  - Outputs the assembled word plus a `word_valid` pulse.
  - Uses the same clock and the same active-low asynchronous reset.
- Top level holds the FSM, the length register, the address counter and the checksum XOR.

## Test plan
- Two-word load: after `start`, stream 00 02 20 08 00 05 01 08 48 20 4C at full rate.
  - `imem_we` at addr 0 with data 0x20080005, then at addr 1 with data 0x01084820.
  - Then `done`=1, `error`=0, `cpu_hold`=0, `words_loaded`=2.
- Bad checksum: same stream with final byte 0x4D.
  - Both words are written.
  - `error`=1, `done`=0, `cpu_hold` stays 1.
- Overflow: with ADDR_WIDTH=8, send length 01 01 (257 words).
  - ERR right after LEN_LO.
  - No `imem_we` pulse; `in_ready`=0.
- Zero length: send 00 00 00 → DONE, `words_loaded`=0, no writes. Then send 00 00 01 after a new `start` → ERR.
- Stalls and reset:
  - Randomly drop `in_valid` during the two-word load: same writes and result as the first scenario.
  - Assert `reset` after 6 data bytes: all outputs go to 0 at once and the state is IDLE.
  - Reload after reset succeeds.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
package imem_loader_pkg;

  // Frame field sizes in bytes.
  localparam int unsigned LenBytes  = 2;
  localparam int unsigned WordBytes = 4;
  localparam int unsigned ByteCntW  = $clog2(WordBytes);

  // Loader FSM states.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLenHi = 3'd1,
    StLenLo = 3'd2,
    StData  = 3'd3,
    StCsum  = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Assembles big-endian 32-bit words from a byte stream; registers each completed
// word together with a one-cycle word_valid pulse.
module imem_loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        last_byte_o
);

  localparam logic [ByteCntW-1:0] LastIdx = ByteCntW'(WordBytes - 1);

  logic [23:0]         shift_q, shift_d;
  logic [ByteCntW-1:0] cnt_q, cnt_d;
  logic [31:0]         word_q, word_d;
  logic                valid_q, valid_d;

  // High when the byte being offered now completes a word.
  assign last_byte_o  = (cnt_q == LastIdx);
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

  // Next-state: shift bytes in MSB first, latch the word on its last byte.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == LastIdx) begin
        word_d  = {shift_q, byte_i};
        valid_d = 1'b1;
      end
    end
  end

  // State registers; reset drops any partial word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a length/data/checksum byte frame, writes words into
// instruction memory and holds the core in reset while loading.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [16:0] DepthC = 17'(2 ** ADDR_WIDTH);

  state_e                state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;

  logic        accept;
  logic        clr;
  logic        data_shift;
  logic [15:0] len_c;
  logic [31:0] asm_word;
  logic        asm_valid;
  logic        asm_last;

  assign accept     = in_valid & in_ready;
  assign data_shift = accept & (state_q == StData);
  assign len_c      = {len_hi_q, in_data};

  imem_loader_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (clr),
    .shift_i      (data_shift),
    .byte_i       (in_data),
    .word_o       (asm_word),
    .word_valid_o (asm_valid),
    .last_byte_o  (asm_last)
  );

  // FSM next-state, frame field capture and checksum accumulation.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    len_d    = len_q;
    csum_d   = csum_q;
    clr      = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLenHi;
          clr     = 1'b1;
          csum_d  = '0;
        end
      end
      StLenHi: begin
        if (accept) begin
          len_hi_d = in_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_c;
          if ({1'b0, len_c} > DepthC) begin
            state_d = StErr;
          end else if (len_c == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ in_data;
          // Earlier words are already counted: each write lands >= 3 cycles
          // before the next word's last byte.
          if (asm_last && (17'(words_q) + 17'd1 == {1'b0, len_q})) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (in_data == csum_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Write address and word count advance on the cycle the write is presented.
  always_comb begin
    addr_d  = addr_q;
    words_d = words_q;
    if (clr) begin
      addr_d  = '0;
      words_d = '0;
    end else if (asm_valid) begin
      addr_d  = addr_q + 1'b1;
      words_d = words_q + 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      len_hi_q <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      csum_q   <= '0;
      words_q  <= '0;
    end else begin
      state_q  <= state_d;
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      csum_q   <= csum_d;
      words_q  <= words_d;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state_q)
      StLenHi, StLenLo, StData, StCsum: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      StErr: begin
        cpu_hold = 1'b1;
        error    = 1'b1;
      end
      StDone: done = 1'b1;
      default: ;
    endcase
  end

  assign imem_we      = asm_valid;
  assign imem_addr    = addr_q;
  assign imem_data    = asm_word;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, bad checksum, overflow,
// zero length, stalls, mid-load reset and reload.
module tb_imem_loader;

  localparam int unsigned AW = 8;

  typedef logic [7:0] byte_q_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          cpu_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  logic [AW-1:0] wr_addr_q[$];
  logic [31:0]   wr_data_q[$];

  imem_loader #(
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Record every instruction-memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic clear_writes();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Offer one byte until accepted; optional random idle gap before it and an
  // optional start pulse raised alongside it.
  task automatic send_byte(input logic [7:0] b, input int unsigned max_gap, input bit with_start);
    int unsigned gap;
    bit ok;
    if (max_gap > 0) begin
      gap = $urandom_range(0, max_gap);
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) cycle();
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    start    = with_start;
    ok       = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = in_ready;
      cycle();
      start = 1'b0;
    end
    if (!ok) check_eq("byte_accept_timeout", {31'b0, ok}, 32'd1);
  endtask

  task automatic send_stream(input byte_q_t s, input int unsigned max_gap, input int start_idx);
    for (int i = 0; i < s.size(); i++) send_byte(s[i], max_gap, (i == start_idx));
    in_valid = 1'b0;
  endtask

  task automatic check_two_writes(input string pfx);
    check_eq({pfx, "_nwr"}, wr_addr_q.size(), 32'd2);
    if (wr_addr_q.size() >= 2) begin
      check_eq({pfx, "_addr0"}, 32'(wr_addr_q[0]), 32'd0);
      check_eq({pfx, "_data0"}, wr_data_q[0], 32'h2008_0005);
      check_eq({pfx, "_addr1"}, 32'(wr_addr_q[1]), 32'd1);
      check_eq({pfx, "_data1"}, wr_data_q[1], 32'h0108_4820);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    check_eq({pfx, "_imem_we"}, {31'b0, imem_we}, 32'd0);
    check_eq({pfx, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
    check_eq({pfx, "_done"}, {31'b0, done}, 32'd0);
    check_eq({pfx, "_error"}, {31'b0, error}, 32'd0);
    check_eq({pfx, "_addr"}, 32'(imem_addr), 32'd0);
    check_eq({pfx, "_data"}, imem_data, 32'd0);
    check_eq({pfx, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic check_done(input string pfx, input logic [31:0] words);
    check_eq({pfx, "_done"}, {31'b0, done}, 32'd1);
    check_eq({pfx, "_error"}, {31'b0, error}, 32'd0);
    check_eq({pfx, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd0);
    check_eq({pfx, "_words"}, 32'(words_loaded), words);
  endtask

  task automatic check_err(input string pfx);
    check_eq({pfx, "_error"}, {31'b0, error}, 32'd1);
    check_eq({pfx, "_done"}, {31'b0, done}, 32'd0);
    check_eq({pfx, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd1);
    check_eq({pfx, "_in_ready"}, {31'b0, in_ready}, 32'd0);
  endtask

  byte_q_t good_s, bad_s, s;

  initial begin
    good_s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h48, 8'h20, 8'h4C};
    bad_s  = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08, 8'h48, 8'h20, 8'h4D};

    #12;
    check_reset_outputs("in_reset");
    reset = 1'b1;
    cycle();
    check_reset_outputs("post_reset");

    // Two-word load at full rate.
    clear_writes();
    pulse_start();
    check_eq("start_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    check_eq("start_in_ready", {31'b0, in_ready}, 32'd1);
    send_stream(good_s, 0, -1);
    check_done("two_word", 32'd2);
    check_two_writes("two_word");

    // Bad checksum: both words still written.
    clear_writes();
    pulse_start();
    send_stream(bad_s, 0, -1);
    check_err("bad_csum");
    check_two_writes("bad_csum");

    // Length overflow: 257 words.
    clear_writes();
    pulse_start();
    send_stream('{8'h01, 8'h01}, 0, -1);
    check_err("overflow");
    repeat (4) cycle();
    check_eq("overflow_nwr", wr_addr_q.size(), 32'd0);

    // Zero length, good then bad checksum.
    clear_writes();
    pulse_start();
    send_stream('{8'h00, 8'h00, 8'h00}, 0, -1);
    check_done("zero_len", 32'd0);
    check_eq("zero_len_nwr", wr_addr_q.size(), 32'd0);
    pulse_start();
    send_stream('{8'h00, 8'h00, 8'h01}, 0, -1);
    check_err("zero_len_bad");

    // Full-depth load: word i is {i,i,i,i}, so the checksum is 0.
    clear_writes();
    s = '{8'h01, 8'h00};
    for (int i = 0; i < 256; i++) repeat (4) s.push_back(8'(i));
    s.push_back(8'h00);
    pulse_start();
    send_stream(s, 0, -1);
    check_done("full_depth", 32'd256);
    check_eq("full_depth_nwr", wr_addr_q.size(), 32'd256);
    if (wr_addr_q.size() == 256) begin
      check_eq("full_depth_last_addr", 32'(wr_addr_q[255]), 32'd255);
      check_eq("full_depth_last_data", wr_data_q[255], 32'hFFFF_FFFF);
      check_eq("full_depth_mid_data", wr_data_q[100], 32'h6464_6464);
    end

    // Random stalls give the same result.
    clear_writes();
    pulse_start();
    send_stream(good_s, 3, -1);
    check_done("stall", 32'd2);
    check_two_writes("stall");

    // Reset after 6 data bytes: outputs clear at once.
    pulse_start();
    send_stream('{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h08}, 0, -1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    cycle();
    reset = 1'b1;
    cycle();
    check_reset_outputs("after_mid_reset");

    // Reload, with start raised alongside a DATA byte (must be ignored).
    clear_writes();
    pulse_start();
    send_stream(good_s, 0, 5);
    check_done("reload", 32'd2);
    check_two_writes("reload");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
